// File: rtl/aes_round_sequencer_if.sv
// Bus between the AES-128 round sequencer and its surroundings: the upstream
// block source, the key expansion unit, the round datapath and the downstream sink.
interface aes_round_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_block;
  logic              key_ready;
  logic [3:0]        rk_idx;
  logic [127:0]      rk_in;
  logic [127:0]      rnd_state;
  logic              rnd_final;
  logic [127:0]      rnd_result;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_block;
  logic              busy;
  logic [CNT_W-1:0]  blk_cnt;

  modport master (
    input  in_valid, in_block, key_ready, rk_in, rnd_result, out_ready,
    output in_ready, rk_idx, rnd_state, rnd_final, out_valid, out_block, busy, blk_cnt
  );

  modport slave (
    output in_valid, in_block, key_ready, rk_in, rnd_result, out_ready,
    input  in_ready, rk_idx, rnd_state, rnd_final, out_valid, out_block, busy, blk_cnt
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encrypt control: owns the block state, round counter and
// handshakes, and time-multiplexes one external round datapath over all rounds.
module aes_round_sequencer #(
  parameter int unsigned NR    = 10,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_round_sequencer_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] NR_L  = 4'(NR);

  logic [1:0]       fsm_q, fsm_d;
  logic [127:0]     state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reset gates in_ready so a handshake can never slip through a reset edge.
  assign bus.in_ready  = (fsm_q == IDLE) && bus.key_ready && rst_n;
  assign bus.rnd_state = state_q;
  assign bus.rnd_final = (fsm_q == ROUND) && (round_q == NR_L);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_block = state_q;
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.blk_cnt   = cnt_q;

  always_comb begin
    case (fsm_q)
      ROUND:   bus.rk_idx = round_q;
      DONE:    bus.rk_idx = NR_L;
      default: bus.rk_idx = 4'd0;
    endcase
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          state_d = bus.in_block ^ bus.rk_in;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        // A low key_ready means the schedule is being reloaded: freeze everything.
        if (bus.key_ready) begin
          state_d = bus.rnd_result;
          if (round_q == NR_L) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d = IDLE;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: behavioural AES-128 key schedule and round model feed the
// sequencer, and a scoreboard checks ciphertexts, control timing and block counts.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;
  logic [127:0] rkTab [16];

  aes_round_sequencer_if #(.CNT_W(32)) bus ();
  aes_round_sequencer_if #(.CNT_W(2))  bus2 ();

  aes_round_sequencer #(.NR(NR), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  aes_round_sequencer #(.NR(NR), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int nCompared = 0;
  int nMismatch = 0;
  int cyc = 0;
  int acceptCount = 0;
  int mPhase = 0;
  int mRound = 0;
  int unsigned mCnt = 0;
  int lastAcc = -1;
  bit started = 0;
  bit randomMode = 0;
  bit b2bMode = 0;
  logic [127:0] lastOut = '0;
  logic [127:0] expQ [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] e;
    inv = 8'h01;
    base = b;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin);
    logic [127:0] t;
    logic [127:0] u;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) begin
      t[127-8*i -: 8] = sbox(s[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]);
    end
    u = t;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        u[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        u[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        u[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        u[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return u ^ k;
  endfunction

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkTab[0];
    for (int r = 1; r <= NR; r++) s = aesRound(s, rkTab[r], r == NR);
    return s;
  endfunction

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])}
              ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 16; r++) begin
      rkTab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    end
  endtask

  assign bus.rk_in       = rkTab[bus.rk_idx];
  assign bus.rnd_result  = aesRound(bus.rnd_state, bus.rk_in, bus.rnd_final);
  assign bus2.in_valid   = bus.in_valid;
  assign bus2.in_block   = bus.in_block;
  assign bus2.key_ready  = bus.key_ready;
  assign bus2.out_ready  = bus.out_ready;
  assign bus2.rk_in      = rkTab[bus2.rk_idx];
  assign bus2.rnd_result = aesRound(bus2.rnd_state, bus2.rk_in, bus2.rnd_final);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    nCompared++;
    nMismatch++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Transaction-level model: accepts push the expected ciphertext, rounds advance on key_ready.
  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (!rst_n) begin
      mPhase = 0;
      mRound = 0;
      mCnt = 0;
      expQ.delete();
    end else begin
      case (mPhase)
        0: if (bus.in_valid && bus.key_ready) begin
          expQ.push_back(aesEncrypt(bus.in_block));
          mPhase = 1;
          mRound = 1;
          acceptCount++;
        end
        1: if (bus.key_ready) begin
          if (mRound == NR) mPhase = 2;
          else mRound++;
        end
        default: if (bus.out_ready) begin
          mPhase = 0;
          mCnt++;
        end
      endcase
    end
  end

  // Monitor: samples mid-cycle, checks control outputs and pops on each output handshake.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("in_ready", bus.in_ready, rst_n && mPhase == 0 && bus.key_ready);
      checkOutput("out_valid", bus.out_valid, mPhase == 2);
      checkOutput("busy", bus.busy, mPhase != 0);
      checkOutput("rk_idx", bus.rk_idx, mPhase == 1 ? mRound : (mPhase == 2 ? NR : 0));
      checkOutput("rnd_final", bus.rnd_final, mPhase == 1 && mRound == NR);
      checkOutput("blk_cnt", bus.blk_cnt, mCnt);
      checkOutput("blk_cnt_w2", bus2.blk_cnt, mCnt % 4);
      checkOutput("out_valid_w2", bus2.out_valid, mPhase == 2);
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          timeoutFail("out_unexpected");
        end else begin
          checkOutput("out_block", bus.out_block, expQ[0]);
          if (bus.out_ready && rst_n) begin
            lastOut = bus.out_block;
            void'(expQ.pop_front());
          end
        end
      end
      if (!b2bMode) lastAcc = -1;
      if (rst_n && bus.in_valid && bus.in_ready) begin
        if (b2bMode && lastAcc >= 0) checkOutput("accept_spacing", cyc - lastAcc, NR + 2);
        lastAcc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randomMode) begin
      bus.key_ready = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] pt);
    int n;
    int k;
    n = acceptCount;
    bus.in_valid = 1'b1;
    bus.in_block = pt;
    k = 0;
    while (acceptCount == n && k < 300) begin
      tick();
      k++;
    end
    if (acceptCount == n) timeoutFail("accept_wait");
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(mPhase == 0 && expQ.size() == 0) && k < limit);
    if (!(mPhase == 0 && expQ.size() == 0)) timeoutFail("idle_wait");
  endtask

  task automatic waitRound(input int r, input int limit);
    int k;
    k = 0;
    while (!(mPhase == 1 && mRound == r) && k < limit) begin
      tick();
      k++;
    end
    if (!(mPhase == 1 && mRound == r)) timeoutFail("round_wait");
  endtask

  initial begin
    logic [127:0] pt;
    int n;
    int k;
    int unsigned base;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_block = '0;
    bus.key_ready = 1'b0;
    bus.out_ready = 1'b0;
    expandKey(C1_KEY);
    repeat (3) tick();
    rst_n = 1'b1;
    bus.key_ready = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(C1_PT);
    waitIdle(60);
    checkOutput("c1_ciphertext", lastOut, C1_CT);

    $display("[TB] backpressure in DONE");
    bus.out_ready = 1'b0;
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    k = 0;
    while (mPhase != 2 && k < 60) begin
      tick();
      k++;
    end
    if (mPhase != 2) timeoutFail("done_wait");
    bus.in_valid = 1'b1;
    bus.in_block = C1_PT;
    repeat (5) tick();
    bus.out_ready = 1'b1;
    n = acceptCount;
    k = 0;
    while (acceptCount == n && k < 20) begin
      tick();
      k++;
    end
    if (acceptCount == n) timeoutFail("held_accept");
    bus.in_valid = 1'b0;
    waitIdle(60);

    $display("[TB] key stall at round 4");
    applyStimulus(C1_PT);
    waitRound(4, 30);
    bus.key_ready = 1'b0;
    repeat (3) tick();
    bus.key_ready = 1'b1;
    waitIdle(60);
    checkOutput("stall_ciphertext", lastOut, C1_CT);

    $display("[TB] reset at round 6");
    applyStimulus(C1_PT);
    waitRound(6, 30);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("reset_blk_cnt", bus.blk_cnt, 0);
    applyStimulus(C1_PT ^ 128'h1);
    waitIdle(60);
    checkOutput("after_reset_blk_cnt", bus.blk_cnt, 1);

    $display("[TB] back-to-back blocks");
    base = mCnt;
    b2bMode = 1'b1;
    n = acceptCount;
    bus.in_valid = 1'b1;
    bus.in_block = C1_PT;
    k = 0;
    while (acceptCount < n + 3 && k < 100) begin
      tick();
      k++;
    end
    if (acceptCount < n + 3) timeoutFail("b2b_accepts");
    bus.in_valid = 1'b0;
    waitIdle(60);
    b2bMode = 1'b0;
    checkOutput("b2b_blk_cnt", bus.blk_cnt, base + 3);
    checkOutput("b2b_ciphertext", lastOut, C1_CT);

    $display("[TB] randomized blocks");
    randomMode = 1'b1;
    for (int b = 0; b < 30; b++) begin
      if (b % 10 == 5) begin
        waitIdle(300);
        bus.key_ready = 1'b0;
        expandKey({$urandom, $urandom, $urandom, $urandom});
        tick();
      end
      repeat ($urandom_range(0, 2)) tick();
      pt = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(pt);
    end
    waitIdle(300);
    randomMode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
